// File: rtl/spi_rx_pkg.sv
// rtl/spi_rx_pkg.sv - shared types and constants for the SPI receive deserialiser
package spi_rx_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        RECEIVE        = 2'd1,
        WAIT_FIFO      = 2'd2,
        WAIT_FIFO_LAST = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        MODE_STD  = 2'd0,
        MODE_QUAD = 2'd1,
        MODE_DUAL = 2'd2
    } rx_mode_e;

    // Shifts one edge worth of sdi bits into the LSBs of the packing register.
    function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] shreg,
                                                   input rx_mode_e mode,
                                                   input logic [3:0] sdi);
        logic [WORD_W-1:0] res;
        case (mode)
            MODE_QUAD: res = {shreg[WORD_W-5:0], sdi[3], sdi[2], sdi[1], sdi[0]};
            MODE_DUAL: res = {shreg[WORD_W-3:0], sdi[1], sdi[0]};
            default:   res = {shreg[WORD_W-2:0], sdi[1]};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/spi_rx_if.sv
// rtl/spi_rx_if.sv - received-word handshake towards the RX FIFO
interface spi_rx_if;
    import spi_rx_pkg::*;

    logic [WORD_W-1:0] data;
    logic              data_valid;
    logic              data_ready;

    modport master (output data, output data_valid, input data_ready);
    modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/spi_rx.sv
// rtl/spi_rx.sv - SPI master receive deserialiser (optional dual mode: SPI_RX_DUAL_EN)
module spi_rx
    import spi_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rx_edge,
    output logic             rx_done,
    input  logic             sdi0,
    input  logic             sdi1,
    input  logic             sdi2,
    input  logic             sdi3,
    input  logic             en_quad_in,
`ifdef SPI_RX_DUAL_EN
    input  logic             en_dual_in,
`endif
    input  logic [CNT_W-1:0] counter_in,
    input  logic             counter_in_upd,
    spi_rx_if.master         rx,
    output logic             clk_en_o
);

    rx_state_e         state, state_d;
    rx_mode_e          mode;
    logic [CNT_W-1:0]  counter, counter_d;
    logic [CNT_W-1:0]  trgt, trgt_m1;
    logic [WORD_W-1:0] shreg, shreg_d, shifted, push_word;
    logic              done, word_end, slot_free, push;

    // Quad wins over dual when both are requested.
    always_comb begin
        mode = MODE_STD;
`ifdef SPI_RX_DUAL_EN
        if (en_dual_in)
            mode = MODE_DUAL;
`endif
        if (en_quad_in)
            mode = MODE_QUAD;
    end

    assign trgt_m1   = trgt - 16'd1;
    assign done      = rx_edge && (state == RECEIVE) && (counter == trgt_m1);
    assign rx_done   = done;
    assign slot_free = !rx.data_valid || rx.data_ready;
    assign shifted   = shift_in(shreg, mode, {sdi3, sdi2, sdi1, sdi0});

    // A word is complete once the last bit position of the 32-bit word is filled.
    always_comb begin
        case (mode)
            MODE_QUAD: word_end = (counter[2:0] == 3'd7);
            MODE_DUAL: word_end = (counter[3:0] == 4'hF);
            default:   word_end = (counter[4:0] == 5'd31);
        endcase
    end

    // Transfer length in edges; zero wraps through the 16-bit counter to 65536 edges.
    always_ff @(posedge clk) begin
        if (rst)
            trgt <= 16'd8;
        else if (counter_in_upd) begin
            case (mode)
                MODE_QUAD: trgt <= {2'b00, counter_in[15:2]};
                MODE_DUAL: trgt <= {1'b0, counter_in[15:1]};
                default:   trgt <= counter_in;
            endcase
        end
    end

    // Sequencer: counts edges, packs bits, and stalls the SPI clock when the FIFO slot is full.
    always_comb begin
        state_d   = state;
        counter_d = counter;
        shreg_d   = shreg;
        clk_en_o  = 1'b0;
        push      = 1'b0;
        push_word = shreg;
        case (state)
            IDLE: begin
                if (en) begin
                    state_d   = RECEIVE;
                    counter_d = '0;
                    shreg_d   = '0;
                end
            end
            RECEIVE: begin
                clk_en_o = 1'b1;
                if (rx_edge) begin
                    counter_d = counter + 16'd1;
                    shreg_d   = shifted;
                    if (done) begin
                        counter_d = '0;
                        if (slot_free) begin
                            push      = 1'b1;
                            push_word = shifted;
                            shreg_d   = '0;
                            state_d   = IDLE;
                        end else begin
                            clk_en_o = 1'b0;
                            state_d  = WAIT_FIFO_LAST;
                        end
                    end else if (word_end) begin
                        if (slot_free) begin
                            push      = 1'b1;
                            push_word = shifted;
                            // Cleared so a short final word comes out right-aligned.
                            shreg_d   = '0;
                        end else begin
                            clk_en_o = 1'b0;
                            state_d  = WAIT_FIFO;
                        end
                    end
                end
            end
            WAIT_FIFO: begin
                if (slot_free) begin
                    push    = 1'b1;
                    shreg_d = '0;
                    state_d = RECEIVE;
                end
            end
            WAIT_FIFO_LAST: begin
                if (slot_free) begin
                    push    = 1'b1;
                    shreg_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, edge counter and packing register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_d;
            counter <= counter_d;
            shreg   <= shreg_d;
        end
    end

    // Output word register; a push in the same cycle as a pop keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx.data       <= '0;
            rx.data_valid <= 1'b0;
        end else if (push) begin
            rx.data       <= push_word;
            rx.data_valid <= 1'b1;
        end else if (rx.data_valid && rx.data_ready) begin
            rx.data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_rx.sv
// tb/tb_spi_rx.sv - directed self-checking bench for spi_rx
`timescale 1ns/1ps
module tb_spi_rx;
    import spi_rx_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        rx_edge = 1'b0;
    logic        rx_done;
    logic        sdi0 = 1'b0, sdi1 = 1'b0, sdi2 = 1'b0, sdi3 = 1'b0;
    logic        en_quad_in = 1'b0;
`ifdef SPI_RX_DUAL_EN
    logic        en_dual_in = 1'b0;
`endif
    logic [15:0] counter_in = 16'd0;
    logic        counter_in_upd = 1'b0;
    logic        clk_en_o;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] popped[$];

    spi_rx_if rx ();

    spi_rx dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .rx_edge        (rx_edge),
        .rx_done        (rx_done),
        .sdi0           (sdi0),
        .sdi1           (sdi1),
        .sdi2           (sdi2),
        .sdi3           (sdi3),
        .en_quad_in     (en_quad_in),
`ifdef SPI_RX_DUAL_EN
        .en_dual_in     (en_dual_in),
`endif
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .rx             (rx.master),
        .clk_en_o       (clk_en_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rx.data_valid && rx.data_ready)
            popped.push_back(rx.data);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pop_at(input int i);
        return (popped.size() > i) ? popped[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic load_len(input logic [15:0] len);
        @(negedge clk);
        counter_in = len;
        counter_in_upd = 1'b1;
        @(negedge clk);
        counter_in_upd = 1'b0;
    endtask

    task automatic start;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    // One sample strobe, issued only while the clock enable is up.
    task automatic send_edge(input logic [3:0] bits, output logic done_seen, output logic ce_seen);
        int guard = 0;
        while (!clk_en_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200)
            check("edge_wait_timeout", 32'd1, 32'd0);
        rx_edge = 1'b1;
        {sdi3, sdi2, sdi1, sdi0} = bits;
        #1;
        done_seen = rx_done;
        ce_seen = clk_en_o;
        @(negedge clk);
        rx_edge = 1'b0;
        @(negedge clk);
    endtask

    // Sends n edges of w bits each (w = 1, 2 or 4) taken MSB-first from stream.
    task automatic run_edges(input int n, input int w, input logic [127:0] stream,
                             output int done_cnt, output logic last_done, output int ce_drops,
                             output logic last_ce);
        logic [127:0] v;
        logic [3:0]   bits;
        logic         d, c;
        done_cnt = 0;
        ce_drops = 0;
        last_done = 1'b0;
        last_ce = 1'b0;
        for (int i = 0; i < n; i++) begin
            v = stream >> ((n - 1 - i) * w);
            case (w)
                1:       bits = {2'b00, v[0], 1'b0};
                2:       bits = {2'b00, v[1:0]};
                default: bits = v[3:0];
            endcase
            send_edge(bits, d, c);
            if (d) done_cnt++;
            if (!c) ce_drops++;
            last_done = d;
            last_ce = c;
        end
    endtask

    task automatic wait_pops(input string tag, input int n);
        int guard = 0;
        while (popped.size() < n && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check(tag, popped.size(), n);
    endtask

    initial begin
        int   dc, drops;
        logic ld, lc;
        rx.data_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_data_valid", {31'd0, rx.data_valid}, 32'd0);
        check("rst_data", rx.data, 32'd0);
        check("rst_clk_en", {31'd0, clk_en_o}, 32'd0);
        check("rst_rx_done", {31'd0, rx_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // std, 32 bits, FIFO always ready
        load_len(16'd32);
        start();
        #1 check("t1_clk_en_receive", {31'd0, clk_en_o}, 32'd1);
        run_edges(32, 1, 128'hA5A5_1234, dc, ld, drops, lc);
        check("t1_done_count", dc, 1);
        check("t1_done_last", {31'd0, ld}, 32'd1);
        check("t1_clk_en_drops", drops, 0);
        wait_pops("t1_pop_count", 1);
        check("t1_word", pop_at(0), 32'hA5A5_1234);
        #1 check("t1_idle_clk_en", {31'd0, clk_en_o}, 32'd0);
        popped.delete();

        // quad, counter_in=64 -> 16 edges, nibbles 0..F
        en_quad_in = 1'b1;
        load_len(16'd64);
        start();
        run_edges(16, 4, 128'h0123_4567_89AB_CDEF, dc, ld, drops, lc);
        check("t2_done_count", dc, 1);
        check("t2_done_last", {31'd0, ld}, 32'd1);
        check("t2_clk_en_drops", drops, 0);
        wait_pops("t2_pop_count", 2);
        check("t2_word0", pop_at(0), 32'h0123_4567);
        check("t2_word1", pop_at(1), 32'h89AB_CDEF);
        en_quad_in = 1'b0;
        popped.delete();

        // std back-pressure mid-transfer: leave one word parked, then 40-bit transfer
        rx.data_ready = 1'b0;
        load_len(16'd32);
        start();
        run_edges(32, 1, 128'h1111_2222, dc, ld, drops, lc);
        @(negedge clk);
        #1;
        check("t3_parked_valid", {31'd0, rx.data_valid}, 32'd1);
        check("t3_parked_data", rx.data, 32'h1111_2222);
        load_len(16'd40);
        start();
        run_edges(32, 1, 128'hDEAD_BEEF, dc, ld, drops, lc);
        check("t3_edge32_clk_en", {31'd0, lc}, 32'd0);
        check("t3_edge32_no_done", dc, 0);
        repeat (4) @(negedge clk);
        #1 check("t3_stall_clk_en", {31'd0, clk_en_o}, 32'd0);
        @(negedge clk);
        rx.data_ready = 1'b1;
        run_edges(8, 1, 128'h5A, dc, ld, drops, lc);
        check("t3_done_last", {31'd0, ld}, 32'd1);
        wait_pops("t3_pop_count", 3);
        check("t3_word0", pop_at(0), 32'h1111_2222);
        check("t3_word1", pop_at(1), 32'hDEAD_BEEF);
        check("t3_word2_partial", pop_at(2), 32'h0000_005A);
        popped.delete();

        // last word with a parked word and FIFO not ready
        rx.data_ready = 1'b0;
        load_len(16'd8);
        start();
        run_edges(8, 1, 128'h3C, dc, ld, drops, lc);
        start();
        run_edges(8, 1, 128'hC3, dc, ld, drops, lc);
        check("t4_done_last", {31'd0, ld}, 32'd1);
        check("t4_last_clk_en", {31'd0, lc}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("t4_hold_data", rx.data, 32'h0000_003C);
        check("t4_hold_valid", {31'd0, rx.data_valid}, 32'd1);
        @(negedge clk);
        rx.data_ready = 1'b1;
        wait_pops("t4_pop_count", 2);
        check("t4_word0", pop_at(0), 32'h0000_003C);
        check("t4_word1", pop_at(1), 32'h0000_00C3);
        @(negedge clk);
        #1 check("t4_valid_cleared", {31'd0, rx.data_valid}, 32'd0);
        popped.delete();

        // reset at edge 17 of a 32-bit transfer, with a word parked
        rx.data_ready = 1'b0;
        start();
        run_edges(8, 1, 128'h77, dc, ld, drops, lc);
        load_len(16'd32);
        start();
        run_edges(17, 1, 128'h1_5555, dc, ld, drops, lc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_valid", {31'd0, rx.data_valid}, 32'd0);
        check("t5_data", rx.data, 32'd0);
        check("t5_clk_en", {31'd0, clk_en_o}, 32'd0);
        rx.data_ready = 1'b1;
        popped.delete();
        start();
        run_edges(8, 1, 128'h96, dc, ld, drops, lc);
        check("t5_trgt8_done_count", dc, 1);
        check("t5_trgt8_done_last", {31'd0, ld}, 32'd1);
        wait_pops("t5_pop_count", 1);
        check("t5_word", pop_at(0), 32'h0000_0096);
        popped.delete();

`ifdef SPI_RX_DUAL_EN
        en_dual_in = 1'b1;
        load_len(16'd32);
        start();
        run_edges(16, 2, 128'hC0FF_EE11, dc, ld, drops, lc);
        check("t6_done_count", dc, 1);
        check("t6_done_last", {31'd0, ld}, 32'd1);
        wait_pops("t6_pop_count", 1);
        check("t6_word", pop_at(0), 32'hC0FF_EE11);
        en_dual_in = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
